// File: rtl/camera_frame_gen_pkg.sv
// Shared definitions for the synthetic camera stream: default geometry, RGB332 colors,
// PATTERN encodings and the frame FSM state type.
package camera_pkg;

  localparam int CAM_SCREEN_WIDTH  = 176;
  localparam int CAM_SCREEN_HEIGHT = 144;
  localparam int CAM_HBLANK_CYCLES = 32;
  localparam int CAM_VSYNC_LINES   = 3;
  localparam int CAM_VBP_LINES     = 4;
  localparam int CAM_VFP_LINES     = 2;
  localparam int CAM_BAR_HEIGHT    = 48;

  localparam logic [7:0] COLOR_RED   = 8'hE0;
  localparam logic [7:0] COLOR_GREEN = 8'h1C;
  localparam logic [7:0] COLOR_BLUE  = 8'h03;
  localparam logic [7:0] COLOR_BLACK = 8'h00;

  localparam logic [1:0] PAT_BLUE  = 2'd0;
  localparam logic [1:0] PAT_RED   = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_BLACK = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC_S,
    VBP,
    ACTIVE,
    VFP
  } state_t;

endpackage

// File: rtl/camera_frame_gen_if.sv
// Pixel/VSYNC/HREF stream bundle between the frame generator (master) and the image processor (slave).
// FRAME_CNT exists only when FRAME_CNT_EN is defined.
interface camera_frame_gen_if;
  logic       EN;
  logic [1:0] PATTERN;
  logic [7:0] PIXEL_OUT;
  logic       HREF;
  logic       VSYNC;
  logic       FRAME_DONE;
`ifdef FRAME_CNT_EN
  logic [15:0] FRAME_CNT;

  modport master (input EN, PATTERN, output PIXEL_OUT, HREF, VSYNC, FRAME_DONE, FRAME_CNT);
  modport slave  (output EN, PATTERN, input PIXEL_OUT, HREF, VSYNC, FRAME_DONE, FRAME_CNT);
`else
  modport master (input EN, PATTERN, output PIXEL_OUT, HREF, VSYNC, FRAME_DONE);
  modport slave  (output EN, PATTERN, input PIXEL_OUT, HREF, VSYNC, FRAME_DONE);
`endif
endinterface

// File: rtl/camera_frame_gen_frame_timing_counter.sv
// Column/line counter pair for the frame generator: column wraps every line period and advances
// the line; reports end-of-line and whether the current line is the last one of the state.
module frame_timing_counter #(
  parameter int LINE_PERIOD = 208,
  parameter int COL_W       = 8,
  parameter int LINE_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic [LINE_W-1:0] i_last_line,
  output logic [COL_W-1:0]  o_col,
  output logic [LINE_W-1:0] o_line,
  output logic              o_eol,
  output logic              o_last_line
);

  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic              w_eol;

  assign w_eol = (r_col == COL_W'(LINE_PERIOD - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (i_clear) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (w_eol) begin
      r_col  <= '0;
      r_line <= r_line + 1'b1;
    end else begin
      r_col  <= r_col + 1'b1;
    end
  end

  assign o_col       = r_col;
  assign o_line      = r_line;
  assign o_eol       = w_eol;
  assign o_last_line = (r_line == i_last_line);

endmodule

// File: rtl/camera_frame_gen.sv
// Synthetic OV7670-style RGB332 frame source with VSYNC/HREF framing and selectable test patterns.
// Define FRAME_CNT_EN to add the 16-bit completed-frame counter on the FRAME_CNT port.
module camera_frame_gen
  import camera_pkg::*;
#(
  parameter int SCREEN_WIDTH  = CAM_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = CAM_SCREEN_HEIGHT,
  parameter int HBLANK_CYCLES = CAM_HBLANK_CYCLES,
  parameter int VSYNC_LINES   = CAM_VSYNC_LINES,
  parameter int VBP_LINES     = CAM_VBP_LINES,
  parameter int VFP_LINES     = CAM_VFP_LINES,
  parameter int BAR_HEIGHT    = CAM_BAR_HEIGHT
) (
  input  logic                CLK,
  input  logic                RESET,
  camera_frame_gen_if.master  bus
);

  localparam int LINE_PERIOD = SCREEN_WIDTH + HBLANK_CYCLES;
  localparam int COL_W       = $clog2(LINE_PERIOD);
  localparam int LINE_W      = $clog2(SCREEN_HEIGHT + VSYNC_LINES + VBP_LINES + VFP_LINES + 1);

  state_t            r_state;
  logic [1:0]        r_pattern;
  logic [7:0]        r_pixel;
  logic              r_href;
  logic              r_vsync;
  logic              r_frame_done;

  logic [COL_W-1:0]  w_col;
  logic [LINE_W-1:0] w_line;
  logic [LINE_W-1:0] w_last_line;
  logic              w_eol;
  logic              w_last_line_hit;
  logic              w_state_end;
  logic              w_clear;
  logic              w_href;

  function automatic logic [7:0] pattern_color(input logic [1:0] pat, input logic [LINE_W-1:0] line);
    logic [7:0] color;
    case (pat)
      PAT_BLUE: color = COLOR_BLUE;
      PAT_RED:  color = COLOR_RED;
      PAT_BARS: begin
        if (line < LINE_W'(BAR_HEIGHT))          color = COLOR_RED;
        else if (line < LINE_W'(2 * BAR_HEIGHT)) color = COLOR_GREEN;
        else                                     color = COLOR_BLUE;
      end
      default:  color = COLOR_BLACK;
    endcase
    return color;
  endfunction

  always_comb begin
    w_last_line = '0;
    case (r_state)
      VSYNC_S: w_last_line = LINE_W'(VSYNC_LINES - 1);
      VBP:     w_last_line = LINE_W'(VBP_LINES - 1);
      ACTIVE:  w_last_line = LINE_W'(SCREEN_HEIGHT - 1);
      VFP:     w_last_line = LINE_W'(VFP_LINES - 1);
      default: w_last_line = '0;
    endcase
  end

  // Counters restart on every state change and are held at zero while idle.
  assign w_state_end = w_eol && w_last_line_hit;
  assign w_clear     = (r_state == IDLE) || w_state_end;
  assign w_href      = (r_state == ACTIVE) && (w_col < COL_W'(SCREEN_WIDTH));

  frame_timing_counter #(
    .LINE_PERIOD (LINE_PERIOD),
    .COL_W       (COL_W),
    .LINE_W      (LINE_W)
  ) u_timing (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_clear     (w_clear),
    .i_last_line (w_last_line),
    .o_col       (w_col),
    .o_line      (w_line),
    .o_eol       (w_eol),
    .o_last_line (w_last_line_hit)
  );

  // Outputs are registered from the current state/counters, so the visible stream trails the FSM by one cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_pattern    <= PAT_BLUE;
      r_pixel      <= COLOR_BLACK;
      r_href       <= 1'b0;
      r_vsync      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_vsync      <= (r_state == VSYNC_S);
      r_href       <= w_href;
      r_pixel      <= w_href ? pattern_color(r_pattern, w_line) : COLOR_BLACK;
      r_frame_done <= (r_state == VFP) && w_state_end;
      case (r_state)
        IDLE: begin
          if (bus.EN) begin
            r_state   <= VSYNC_S;
            r_pattern <= bus.PATTERN;
          end
        end
        VSYNC_S: if (w_state_end) r_state <= VBP;
        VBP:     if (w_state_end) r_state <= ACTIVE;
        ACTIVE:  if (w_state_end) r_state <= VFP;
        VFP: begin
          if (w_state_end) begin
            if (bus.EN) begin
              r_state   <= VSYNC_S;
              r_pattern <= bus.PATTERN;
            end else begin
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.PIXEL_OUT  = r_pixel;
  assign bus.HREF       = r_href;
  assign bus.VSYNC      = r_vsync;
  assign bus.FRAME_DONE = r_frame_done;

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_frame_cnt <= '0;
    end else if (r_frame_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.FRAME_CNT = r_frame_cnt;
`endif

endmodule

// File: tb/tb_camera_frame_gen.sv
// Directed bench for camera_frame_gen at default geometry: reset, red/black partial frames,
// and two back-to-back frames covering pattern latching, bars, framing counts and EN drop.
module tb_camera_frame_gen;

  localparam int W     = 176;
  localparam int H     = 144;
  localparam int L     = 208;
  localparam int VS    = 3;
  localparam int VB    = 4;
  localparam int BAR   = 48;
  localparam int FRAME = 31824;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  camera_frame_gen_if bus ();

  camera_frame_gen dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic test_reset();
    int nz;
    @(negedge clk);
    checks++;
    if ({bus.PIXEL_OUT, bus.HREF, bus.VSYNC, bus.FRAME_DONE} !== 11'h0) begin
      errors++;
      $display("FAIL reset_state got %h expected 000", {bus.PIXEL_OUT, bus.HREF, bus.VSYNC, bus.FRAME_DONE});
    end
    rst = 1'b0;
    bus.PATTERN = 2'd1;
    bus.EN = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.VSYNC !== 1'b0) begin
      errors++;
      $display("FAIL vsync_early got %b expected 0", bus.VSYNC);
    end
    @(negedge clk);
    checks++;
    if (bus.VSYNC !== 1'b1) begin
      errors++;
      $display("FAIL vsync_rise got %b expected 1", bus.VSYNC);
    end
    repeat (1455) @(negedge clk);
    checks++;
    if (bus.HREF !== 1'b0) begin
      errors++;
      $display("FAIL href_before_1456 got %b expected 0", bus.HREF);
    end
    @(negedge clk);
    checks++;
    if (bus.HREF !== 1'b1 || bus.PIXEL_OUT !== 8'hE0) begin
      errors++;
      $display("FAIL red_first_pixel got href=%b pix=%h expected href=1 pix=e0", bus.HREF, bus.PIXEL_OUT);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    bus.EN = 1'b0;
    #1;
    checks++;
    if ({bus.PIXEL_OUT, bus.HREF, bus.VSYNC, bus.FRAME_DONE} !== 11'h0) begin
      errors++;
      $display("FAIL reset_mid_active got %h expected 000", {bus.PIXEL_OUT, bus.HREF, bus.VSYNC, bus.FRAME_DONE});
    end
    @(negedge clk);
    rst = 1'b0;
    nz = 0;
    repeat (500) begin
      @(negedge clk);
      if ({bus.PIXEL_OUT, bus.HREF, bus.VSYNC, bus.FRAME_DONE} !== 11'h0) nz++;
    end
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL idle_after_reset nonzero_cycles got %0d expected 0", nz);
    end
  endtask

  task automatic test_black();
    int href_cnt, first_href, pix_nz;
    href_cnt = 0;
    first_href = -1;
    pix_nz = 0;
    bus.PATTERN = 2'd3;
    bus.EN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.VSYNC !== 1'b1) begin
      errors++;
      $display("FAIL black_vsync_rise got %b expected 1", bus.VSYNC);
    end
    for (int t = 0; t < 1456 + L; t++) begin
      if (t > 0) @(negedge clk);
      if (bus.HREF === 1'b1) begin
        href_cnt++;
        if (first_href < 0) first_href = t;
      end
      if (bus.PIXEL_OUT !== 8'h00) pix_nz++;
    end
    checks++;
    if (href_cnt !== W || first_href !== 1456) begin
      errors++;
      $display("FAIL black_line href_cnt=%0d first=%0d expected 176 and 1456", href_cnt, first_href);
    end
    checks++;
    if (pix_nz !== 0) begin
      errors++;
      $display("FAIL black_pixels nonzero got %0d expected 0", pix_nz);
    end
    bus.EN = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int vs_cnt[2], href_cnt[2], first_href[2], done_cnt[2], done_pos[2];
    int mm[2], overlap[2], blank_nz[2], line_bad[2], bar_ok[3];
    int line_href, nz;
    for (int f = 0; f < 2; f++) begin
      vs_cnt[f] = 0; href_cnt[f] = 0; first_href[f] = -1; done_cnt[f] = 0; done_pos[f] = -1;
      mm[f] = 0; overlap[f] = 0; blank_nz[f] = 0; line_bad[f] = 0;
    end
    for (int r = 0; r < 3; r++) bar_ok[r] = 0;
    line_href = 0;
    bus.PATTERN = 2'd0;
    bus.EN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.VSYNC !== 1'b1) begin
      errors++;
      $display("FAIL b2b_vsync_rise got %b expected 1", bus.VSYNC);
    end
    for (int t = 0; t < 2 * FRAME; t++) begin
      int f, c, pos, col, line;
      logic ex_vs, ex_hr, ex_dn;
      logic [7:0] ex_px, color;
      if (t > 0) @(negedge clk);
      f = t / FRAME;
      c = t % FRAME;
      pos = c / L;
      col = c % L;
      line = pos - (VS + VB);
      if (f == 0 && pos == VS + VB + 70 && col == 0) bus.PATTERN = 2'd2;
      if (f == 1 && pos == VS + VB + 80 && col == 0) bus.EN = 1'b0;
      ex_vs = (pos < VS);
      ex_hr = (line >= 0) && (line < H) && (col < W);
      if (f == 0)               color = 8'h03;
      else if (line < BAR)      color = 8'hE0;
      else if (line < 2 * BAR)  color = 8'h1C;
      else                      color = 8'h03;
      ex_px = ex_hr ? color : 8'h00;
      ex_dn = (c == FRAME - 1);
      if (bus.VSYNC !== ex_vs || bus.HREF !== ex_hr || bus.PIXEL_OUT !== ex_px || bus.FRAME_DONE !== ex_dn)
        mm[f]++;
      if (bus.VSYNC === 1'b1) vs_cnt[f]++;
      if (bus.HREF === 1'b1) begin
        href_cnt[f]++;
        line_href++;
        if (first_href[f] < 0) first_href[f] = c;
        if (f == 1 && bus.PIXEL_OUT === color) bar_ok[line / BAR]++;
      end else if (bus.PIXEL_OUT !== 8'h00) begin
        blank_nz[f]++;
      end
      if (bus.FRAME_DONE === 1'b1) begin
        done_cnt[f]++;
        done_pos[f] = c;
      end
      if (bus.HREF === 1'b1 && bus.VSYNC === 1'b1) overlap[f]++;
      if (col == L - 1) begin
        if (line >= 0 && line < H && line_href != W) line_bad[f]++;
        line_href = 0;
      end
    end
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (vs_cnt[f] !== 624) begin
        errors++;
        $display("FAIL f%0d_vsync_cycles got %0d expected 624", f, vs_cnt[f]);
      end
      checks++;
      if (first_href[f] !== 1456) begin
        errors++;
        $display("FAIL f%0d_first_href got %0d expected 1456", f, first_href[f]);
      end
      checks++;
      if (href_cnt[f] !== 25344) begin
        errors++;
        $display("FAIL f%0d_href_cycles got %0d expected 25344", f, href_cnt[f]);
      end
      checks++;
      if (done_cnt[f] !== 1 || done_pos[f] !== FRAME - 1) begin
        errors++;
        $display("FAIL f%0d_frame_done count=%0d pos=%0d expected 1 at 31823", f, done_cnt[f], done_pos[f]);
      end
      checks++;
      if (mm[f] !== 0) begin
        errors++;
        $display("FAIL f%0d_stream_model mismatched_cycles got %0d expected 0", f, mm[f]);
      end
      checks++;
      if (overlap[f] !== 0 || blank_nz[f] !== 0) begin
        errors++;
        $display("FAIL f%0d_blank overlap=%0d blank_nonzero=%0d expected 0 0", f, overlap[f], blank_nz[f]);
      end
      checks++;
      if (line_bad[f] !== 0) begin
        errors++;
        $display("FAIL f%0d_line_width bad_lines got %0d expected 0", f, line_bad[f]);
      end
    end
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (bar_ok[r] !== BAR * W) begin
        errors++;
        $display("FAIL bar%0d_pixels got %0d expected %0d", r, bar_ok[r], BAR * W);
      end
    end
    nz = 0;
    repeat (400) begin
      @(negedge clk);
      if ({bus.PIXEL_OUT, bus.HREF, bus.VSYNC, bus.FRAME_DONE} !== 11'h0) nz++;
    end
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL idle_after_en_drop nonzero_cycles got %0d expected 0", nz);
    end
`ifdef FRAME_CNT_EN
    checks++;
    if (bus.FRAME_CNT !== 16'd2) begin
      errors++;
      $display("FAIL frame_cnt got %0d expected 2", bus.FRAME_CNT);
    end
`endif
  endtask

  initial begin
    bus.EN = 1'b0;
    bus.PATTERN = 2'd0;
    test_reset();
    test_black();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
